// File: rtl/nfca_rx_frame_assembler_if.sv
// nfca_rx_frame_assembler_if: byte-beat stream from the NFC-A frame assembler to the host packetiser
interface nfca_rx_frame_assembler_if;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic [3:0] m_tdatab;
  logic       m_tend;
  logic       m_terr;
  logic       m_tcol;
  logic       m_tcrcok;
  modport master(output m_tvalid, m_tdata, m_tdatab, m_tend, m_terr, m_tcol, m_tcrcok, input m_tready);
  modport slave(input m_tvalid, m_tdata, m_tdatab, m_tend, m_terr, m_tcol, m_tcrcok, output m_tready);
endinterface

// File: rtl/nfca_rx_frame_assembler.sv
// nfca_rx_frame_assembler: packs NFC-A RX bits into parity/CRC_A checked byte beats behind a FWFT FIFO
module nfca_rx_frame_assembler #(
  parameter int FIFO_DEPTH = 16,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit CRC_EN     = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_on,
  input  logic [2:0]                      remainb,
  input  logic                            rx_bit_en,
  input  logic                            rx_bit,
  input  logic                            rx_end,
  input  logic                            rx_end_col,
  input  logic                            rx_end_err,
  nfca_rx_frame_assembler_if.master       m,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, PARSE, PAR, CSTOP, STOP} state_t;
  typedef struct packed {logic [7:0] d; logic [3:0] b; logic e, r, c, k;} beat_t;
  state_t r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic [7:0] r_byte, w_byte_n, w_bb;
  logic [15:0] r_crc, w_crc_n;
  logic [1:0] r_nb, w_nb_n;
  logic r_ferr, w_ferr_n, r_rx_on_d, w_push, w_pop, w_full, w_wr, w_drop, w_crcok;
  beat_t w_beat, w_head;
  beat_t r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;

  function automatic logic [15:0] crc_a(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 0; i < 8; i++) x = (x >> 1) ^ ((x[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    return x;
  endfunction

  function automatic beat_t mk(input logic [7:0] d, input logic [3:0] b, input logic e, r, c, k);
    return '{d, b, e, r, c, k};
  endfunction

  assign w_bb    = r_byte | (8'(rx_bit) << r_cnt[2:0]);
  assign w_crcok = CRC_EN && r_crc == 16'h0000 && r_nb == 2'd3;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_byte_n  = r_byte;
    w_crc_n   = r_crc;
    w_nb_n    = r_nb;
    w_ferr_n  = r_ferr;
    w_push    = 1'b0;
    w_beat    = '0;
    if (r_state == CSTOP) begin
      w_push    = 1'b1;
      w_beat    = mk(8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      w_state_n = STOP;
    end else if (!rx_on) begin
      // closing the window mid-byte (or before parity) means the frame ran long
      w_push    = (r_state == PARSE && r_cnt != 4'd0) || r_state == PAR;
      w_beat    = mk(r_byte, r_cnt, 1'b1, 1'b1, 1'b0, 1'b0);
      w_cnt_n   = {1'b0, remainb};
      w_byte_n  = '0;
      w_crc_n   = 16'h6363;
      w_nb_n    = '0;
      w_ferr_n  = 1'b0;
      w_state_n = IDLE;
    end else if (r_state == IDLE) begin
      w_state_n = PARSE;
    end else if (r_state == STOP) begin
      w_state_n = STOP;
    end else if (rx_bit_en) begin
      if (r_state == PAR) begin
        w_push = 1'b1;
        if (^{rx_bit, r_byte}) begin
          w_beat    = mk(r_byte, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
          w_crc_n   = crc_a(r_crc, r_byte);
          w_nb_n    = r_nb + {1'b0, r_nb != 2'd3};
          w_cnt_n   = '0;
          w_byte_n  = '0;
          w_state_n = PARSE;
        end else begin
          w_beat    = mk(r_byte, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
          w_state_n = STOP;
        end
      end else if (r_cnt == 4'd7 && !PARITY_EN) begin
        w_push   = 1'b1;
        w_beat   = mk(w_bb, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        w_crc_n  = crc_a(r_crc, w_bb);
        w_nb_n   = r_nb + {1'b0, r_nb != 2'd3};
        w_cnt_n  = '0;
        w_byte_n = '0;
      end else begin
        w_byte_n  = w_bb;
        w_cnt_n   = r_cnt + 4'd1;
        w_state_n = r_cnt == 4'd7 ? PAR : PARSE;
      end
    end else if (rx_end) begin
      w_push    = 1'b1;
      w_state_n = rx_end_col ? CSTOP : STOP;
      w_beat    = rx_end_col ? mk(r_byte, r_cnt, 1'b0, 1'b0, 1'b1, 1'b0) :
                  (rx_end_err || r_cnt != 4'd0 || r_state == PAR) ? mk(r_byte, r_cnt, 1'b1, 1'b1, 1'b0, 1'b0) :
                  mk(8'h00, 4'd0, 1'b1, r_ferr, 1'b0, w_crcok);
    end
  end

  assign w_full = r_level == LW'(FIFO_DEPTH);
  assign w_pop  = m.m_tvalid & m.m_tready;
  assign w_wr   = w_push & (!w_full | w_pop);
  assign w_drop = w_push & w_full & !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_byte    <= '0;
      r_crc     <= 16'h6363;
      r_nb      <= '0;
      r_ferr    <= 1'b0;
      r_rx_on_d <= 1'b0;
      ovf       <= 1'b0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_level   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_byte    <= w_byte_n;
      r_crc     <= w_crc_n;
      r_nb      <= w_nb_n;
      r_ferr    <= w_ferr_n | (w_drop & rx_on);
      r_rx_on_d <= rx_on;
      ovf       <= w_drop | (ovf & !(rx_on & !r_rx_on_d));
      r_wp      <= r_wp + AW'(w_wr);
      r_rp      <= r_rp + AW'(w_pop);
      r_level   <= r_level + LW'(w_wr) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk) if (w_wr) r_mem[r_wp] <= w_beat;

  // head is gated so an empty FIFO presents all-zero outputs
  assign w_head     = m.m_tvalid ? r_mem[r_rp] : '0;
  assign m.m_tvalid = r_level != '0;
  assign m.m_tdata  = w_head.d;
  assign m.m_tdatab = w_head.b;
  assign m.m_tend   = w_head.e;
  assign m.m_terr   = w_head.r;
  assign m.m_tcol   = w_head.c;
  assign m.m_tcrcok = w_head.k;
  assign fifo_level = r_level;
endmodule

// File: tb/tb_nfca_rx_frame_assembler.sv
// tb_nfca_rx_frame_assembler: scoreboard bench with a frame-level reference model of the NFC-A RX assembler
module tb_nfca_rx_frame_assembler;
  logic clk = 1'b0, rst = 1'b1, rx_on = 1'b0, rx_bit_en = 1'b0, rx_bit = 1'b0;
  logic rx_end = 1'b0, rx_end_col = 1'b0, rx_end_err = 1'b0;
  logic [2:0] remainb = 3'd0;
  logic [4:0] fifo_level;
  logic ovf;
  logic [15:0] exp_q[$];
  logic [7:0] fd[$];
  int n_vec = 0, n_bad = 0, rmode = 2;

  nfca_rx_frame_assembler_if m();
  nfca_rx_frame_assembler #(.FIFO_DEPTH(16), .PARITY_EN(1'b1), .CRC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_on(rx_on), .remainb(remainb), .rx_bit_en(rx_bit_en), .rx_bit(rx_bit),
    .rx_end(rx_end), .rx_end_col(rx_end_col), .rx_end_err(rx_end_err), .m(m),
    .fifo_level(fifo_level), .ovf(ovf));

  always #5 clk = ~clk;

  initial begin
    m.m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m.m_tready = rmode == 2 ? 1'b1 : rmode == 1 ? 1'b0 : ($urandom % 4 != 0);
    end
  end

  always @(negedge clk) begin
    logic [15:0] act, e;
    if (!rst && m.m_tvalid && m.m_tready) begin
      act = {m.m_tdata, m.m_tdatab, m.m_tend, m.m_terr, m.m_tcol, m.m_tcrcok};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat: got %h, required none pending", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL beat {d,b,e,r,c,k}: got %h, required %h", act, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, e);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_bit_en = 1'b1;
    rx_bit = b;
    cyc(1);
    rx_bit_en = 1'b0;
    cyc($urandom % 3);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m.m_tvalid) && t < 3000) begin
      cyc(1);
      t++;
    end
    chk("drain pending", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] c = 16'h6363;
    foreach (q[i]) begin
      c ^= {8'h00, q[i]};
      repeat (8) c = c[0] ? (c >> 1) ^ 16'h8408 : c >> 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] bt(input logic [7:0] d, input int b, input bit e, r, c, k);
    return {d, 4'(b), e, r, c, k};
  endfunction

  // fd: bytes; r: remainb; pb: byte with bad parity (-1 none); k/v: trailing bits; et: 0 end,1 col,2 err,3 window drop
  task automatic frame(input int r, input int pb, input int k, input logic [7:0] v, input int et);
    int nd = fd.size();
    int cnt;
    bit stop = 0;
    logic [7:0] val;
    logic [7:0] pre[$];
    if (nd > 0) fd[0] = fd[0] & (8'hFF << r);
    for (int i = 0; i < nd && !stop; i++) begin
      if (i == pb) begin
        exp_q.push_back(bt(fd[i], 8, 1, 1, 0, 0));
        stop = 1;
      end else begin
        exp_q.push_back(bt(fd[i], 8, 0, 0, 0, 0));
        pre.push_back(fd[i]);
      end
    end
    if (!stop) begin
      cnt = (nd == 0 ? r : 0) + k;
      val = (v & 8'((1 << k) - 1)) << (nd == 0 ? r : 0);
      if (et == 1) begin
        exp_q.push_back(bt(val, cnt, 0, 0, 1, 0));
        exp_q.push_back(bt(8'h00, 0, 1, 0, 1, 0));
      end else if (et == 2 || cnt != 0) exp_q.push_back(bt(val, cnt, 1, 1, 0, 0));
      else if (et == 0) exp_q.push_back(bt(8'h00, 0, 1, 0, 0, nd >= 3 && crc_of(pre) == 16'h0000));
    end
    rx_on = 1'b0;
    remainb = 3'(r);
    cyc(1 + $urandom % 2);
    rx_on = 1'b1;
    rx_bit_en = 1'b1;
    rx_bit = 1'b1;
    cyc(1);
    rx_bit_en = 1'b0;
    for (int i = 0; i < nd; i++) begin
      for (int j = (i == 0 ? r : 0); j < 8; j++) send_bit(fd[i][j]);
      send_bit(~^fd[i] ^ (i == pb));
      if (i == pb) break;
    end
    if (!stop) for (int j = 0; j < k; j++) send_bit(v[j]);
    if (et != 3) begin
      rx_end = 1'b1;
      rx_end_col = et == 1;
      rx_end_err = et == 2;
      cyc(1);
      {rx_end, rx_end_col, rx_end_err} = 3'b000;
      cyc(2);
      send_bit(1'b1);
      rx_end = 1'b1;
      cyc(1);
      rx_end = 1'b0;
    end
    rx_on = 1'b0;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("reset tvalid", m.m_tvalid, 0);
    chk("reset level", fifo_level, 0);
    chk("reset ovf", ovf, 0);
    fd = '{8'h26};
    frame(0, -1, 0, 8'h00, 0);
    fd = '{8'h26};
    frame(0, 0, 0, 8'h00, 0);
    fd = '{};
    frame(0, -1, 3, 8'b101, 1);
    fd = '{8'h50, 8'h00, 8'h57, 8'hCD};
    frame(0, -1, 0, 8'h00, 0);
    fd = '{8'h50, 8'h00, 8'h57, 8'hCC};
    frame(0, -1, 0, 8'h00, 0);
    fd = '{};
    frame(0, -1, 4, 8'h0B, 3);
    fd = '{8'h93, 8'h20};
    frame(3, -1, 2, 8'h03, 2);
    drain();
    rmode = 0;
    for (int f = 0; f < 40; f++) begin
      int r, nd, k, pb, et;
      logic [15:0] c;
      r = ($urandom % 4 == 0) ? $urandom % 8 : 0;
      nd = $urandom % 6;
      fd = '{};
      for (int i = 0; i < nd; i++) fd.push_back(8'($urandom));
      if (nd > 0) fd[0] = fd[0] & (8'hFF << r);
      if (r == 0 && nd > 0 && $urandom % 2 == 0) begin
        c = crc_of(fd);
        fd.push_back(c[7:0]);
        fd.push_back(c[15:8]);
        nd += 2;
      end
      pb = (nd > 0 && $urandom % 8 == 0) ? $urandom % nd : -1;
      k = nd == 0 ? $urandom % (8 - r) : ($urandom % 3 == 0 ? $urandom % 8 : 0);
      et = $urandom % 4;
      frame(r, pb, k, 8'($urandom), et);
    end
    drain();
    rmode = 1;
    fd = '{};
    for (int i = 0; i < 17; i++) fd.push_back(8'($urandom));
    frame(0, -1, 0, 8'h00, 0);
    chk("overflow level", fifo_level, 16);
    chk("overflow ovf", ovf, 1);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    rmode = 0;
    drain();
    chk("ovf sticky", ovf, 1);
    remainb = 3'd0;
    rx_on = 1'b1;
    cyc(1);
    chk("ovf cleared on rx_on", ovf, 0);
    rx_on = 1'b0;
    cyc(2);
    rmode = 1;
    rx_on = 1'b1;
    cyc(1);
    for (int j = 0; j < 8; j++) send_bit(j % 3 == 0);
    send_bit(1'b0);
    for (int j = 0; j < 4; j++) send_bit(1'b1);
    chk("pre-reset level", fifo_level, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid-frame reset tvalid", m.m_tvalid, 0);
    chk("mid-frame reset tdata", {m.m_tdata, m.m_tdatab, m.m_tend, m.m_terr, m.m_tcol, m.m_tcrcok}, 0);
    chk("mid-frame reset level", fifo_level, 0);
    chk("mid-frame reset ovf", ovf, 0);
    rx_on = 1'b0;
    rmode = 0;
    cyc(3);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
